imem_uart_loader: RTL and testbench

- Program loader that fills the instruction memory of the pipelined MIPS core from a byte stream, normally the output of a UART receiver.
- It replaces file preloading of instruction memory in hardware builds.
- It holds the core in reset while loading. It releases the core only after the length and checksum of the image are validated.
- It sits between the byte source and the instruction-memory write port, and it drives the core's active-low reset.

---
 rtl/imem_uart_loader.sv | 135 +++++++++++++
 tb/tb_imem_uart_loader.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/imem_uart_loader.sv
// rtl/imem_uart_loader.sv - byte-stream loader for instruction memory with length/checksum validation
// Holds the core in reset until a complete, checksum-valid image has been written.
module imem_uart_loader #(
  parameter int          ADDR_WIDTH     = 8,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_rst_n,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int          TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [16:0] MAX_LEN = 17'(2 ** ADDR_WIDTH);

  typedef enum logic [2:0] {
    S_SYNC, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERROR
  } state_t;

  state_t          state;
  logic [7:0]      len_hi;
  logic [15:0]     len;
  logic [1:0]      byte_cnt;
  logic [23:0]     word_sr;
  logic [7:0]      csum;
  logic [TW-1:0]   tcnt;

  logic accept;
  logic restart;
  logic timing;

  assign accept  = in_valid && in_ready;
  assign restart = accept && (in_data == SYNC_BYTE) &&
                   (state == S_SYNC || state == S_DONE || state == S_ERROR);
  assign timing  = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                   (state == S_DATA)   || (state == S_CSUM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_SYNC;
      in_ready     <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_rst_n    <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      len_hi       <= '0;
      len          <= '0;
      byte_cnt     <= '0;
      word_sr      <= '0;
      csum         <= '0;
      tcnt         <= '0;
    end else begin
      in_ready <= 1'b1;
      imem_we  <= 1'b0;

      // Address/count advance in the cycle after each write strobe.
      if (imem_we) begin
        imem_addr    <= imem_addr + 1'b1;
        words_loaded <= words_loaded + 1'b1;
      end

      if (!timing || accept) tcnt <= '0;
      else                   tcnt <= tcnt + 1'b1;

      if (restart) begin
        state        <= S_LEN_HI;
        cpu_rst_n    <= 1'b0;
        done         <= 1'b0;
        error        <= 1'b0;
        imem_addr    <= '0;
        words_loaded <= '0;
        csum         <= '0;
        byte_cnt     <= '0;
      end else if (timing && !accept && tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state     <= S_ERROR;
        error     <= 1'b1;
        cpu_rst_n <= 1'b0;
      end else if (accept) begin
        case (state)
          S_LEN_HI: begin
            len_hi <= in_data;
            state  <= S_LEN_LO;
          end
          S_LEN_LO: begin
            len <= {len_hi, in_data};
            if ({1'b0, len_hi, in_data} > MAX_LEN) begin
              state <= S_ERROR;
              error <= 1'b1;
            end else if ({len_hi, in_data} == 16'd0) begin
              state <= S_CSUM;
            end else begin
              state    <= S_DATA;
              byte_cnt <= '0;
            end
          end
          S_DATA: begin
            word_sr  <= {word_sr[15:0], in_data};
            csum     <= csum ^ in_data;
            byte_cnt <= byte_cnt + 1'b1;
            // word_sr keeps assembling while imem_wdata holds the word being written.
            if (byte_cnt == 2'd3) begin
              imem_we    <= 1'b1;
              imem_wdata <= {word_sr, in_data};
              if (16'(words_loaded) + 16'd1 == len) state <= S_CSUM;
            end
          end
          S_CSUM: begin
            if (in_data == csum) begin
              state     <= S_DONE;
              done      <= 1'b1;
              cpu_rst_n <= 1'b1;
            end else begin
              state <= S_ERROR;
              error <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_uart_loader.sv
// tb/tb_imem_uart_loader.sv - directed self-checking bench for imem_uart_loader
// Frames are sent back to back; write strobes are logged at the falling edge.
module tb_imem_uart_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst_n;
  logic        done;
  logic        error;
  logic [8:0]  words_loaded;

  imem_uart_loader #(
    .ADDR_WIDTH     (8),
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_rst_n    (cpu_rst_n),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          wr_cnt   = 0;
  int          base;
  logic [7:0]  wr_addr [64];
  logic [31:0] wr_data [64];
  logic [7:0]  frame [$];

  always @(negedge clk) begin
    if (!rst && imem_we) begin
      if (wr_cnt < 64) begin
        wr_addr[wr_cnt] = imem_addr;
        wr_data[wr_cnt] = imem_wdata;
      end
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame();
    foreach (frame[i]) send_byte(frame[i]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  32'(in_ready), 32'd0);
    check({tag, "_we"},        32'(imem_we), 32'd0);
    check({tag, "_addr"},      32'(imem_addr), 32'd0);
    check({tag, "_wdata"},     imem_wdata, 32'd0);
    check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
    check({tag, "_done"},      32'(done), 32'd0);
    check({tag, "_error"},     32'(error), 32'd0);
    check({tag, "_words"},     32'(words_loaded), 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_rst", 32'(in_ready), 32'd1);

    // Good two-word frame; checksum is the XOR of the eight data bytes (0x8D).
    base  = wr_cnt;
    frame = '{8'hA5, 8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05,
              8'hAC, 8'h08, 8'h00, 8'h00, 8'h8D};
    send_frame();
    check("f1_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    check("f1_done",      32'(done), 32'd1);
    check("f1_error",     32'(error), 32'd0);
    check("f1_words",     32'(words_loaded), 32'd2);
    check("f1_nwrites",   32'(wr_cnt - base), 32'd2);
    check("f1_addr0",     32'(wr_addr[base]), 32'd0);
    check("f1_data0",     wr_data[base], 32'h24080005);
    check("f1_addr1",     32'(wr_addr[base+1]), 32'd1);
    check("f1_data1",     wr_data[base+1], 32'hAC080000);

    // Same frame with a bad checksum byte.
    base  = wr_cnt;
    frame = '{8'hA5, 8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05,
              8'hAC, 8'h08, 8'h00, 8'h00, 8'h84};
    send_frame();
    check("f2_error",     32'(error), 32'd1);
    check("f2_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("f2_done",      32'(done), 32'd0);
    check("f2_nwrites",   32'(wr_cnt - base), 32'd2);

    // LEN = 257 exceeds a 256-word memory.
    base = wr_cnt;
    send_byte(8'hA5);
    check("len_sync_clears_err", 32'(error), 32'd0);
    send_byte(8'h01);
    send_byte(8'h01);
    check("len_error",   32'(error), 32'd1);
    check("len_nwrites", 32'(wr_cnt - base), 32'd0);
    check("len_words",   32'(words_loaded), 32'd0);

    // Timeout after a partial word.
    base  = wr_cnt;
    frame = '{8'hA5, 8'h00, 8'h01, 8'h11, 8'h22};
    send_frame();
    repeat (49) @(posedge clk);
    #1;
    check("to_err_at_49", 32'(error), 32'd0);
    @(posedge clk);
    #1;
    check("to_err_at_50", 32'(error), 32'd1);
    check("to_nwrites",   32'(wr_cnt - base), 32'd0);
    check("to_ready",     32'(in_ready), 32'd1);

    // Zero-length image.
    frame = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_frame();
    check("z_done",      32'(done), 32'd1);
    check("z_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    check("z_words",     32'(words_loaded), 32'd0);

    // Reload from DONE: one word DEADBEEF, checksum 0x22.
    base = wr_cnt;
    send_byte(8'hA5);
    check("rl_cpu_rst_n_drop", 32'(cpu_rst_n), 32'd0);
    check("rl_done_drop",      32'(done), 32'd0);
    frame = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_frame();
    check("rl_we",    32'(imem_we), 32'd1);
    check("rl_addr",  32'(imem_addr), 32'd0);
    check("rl_wdata", imem_wdata, 32'hDEADBEEF);
    send_byte(8'h22);
    check("rl_we_pulse",   32'(imem_we), 32'd0);
    check("rl_done",       32'(done), 32'd1);
    check("rl_cpu_rst_n",  32'(cpu_rst_n), 32'd1);
    check("rl_words",      32'(words_loaded), 32'd1);
    check("rl_nwrites",    32'(wr_cnt - base), 32'd1);

    // rst in the middle of DATA, then a fresh load from SYNC.
    frame = '{8'hA5, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_frame();
    check("mid_words_before", 32'(words_loaded), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("mid_rst");
    rst = 1'b0;
    base  = wr_cnt;
    frame = '{8'h55, 8'hA5, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    send_frame();
    check("post_done",    32'(done), 32'd1);
    check("post_nwrites", 32'(wr_cnt - base), 32'd1);
    check("post_addr",    32'(wr_addr[base]), 32'd0);
    check("post_data",    wr_data[base], 32'h01020304);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
